u409_address_decode_ac: RTL and testbench
=========================================

Name: u409_address_decode_ac

Overview:
- Registered successor to the Zorro 2 address decoder.
- Latches decode results once per bus cycle on TSn, so outputs stay stable for the whole cycle.
- Adds a Zorro II autoconfig engine for N_BOARDS chained 64 KB I/O boards, with base-address match chip selects per board.
- Sits in U409 between the CPU local bus and the ROM, CIA, Agnus (U712) and on-board I/O selects.

Parameters:
- N_BOARDS, 2, number of chained autoconfig boards, legal range 1..4.
- AC_BASE, 8'hE8, A[23:16] of the autoconfig space.
- MFG_ID, 16'h0000, manufacturer ID presented by every board.
- PRODUCT_ID, 8'h00, product ID of board 0; board k presents PRODUCT_ID+k.

Ports:
- CLK40  in  1  system clock; all state changes on the rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- TSn  in  1  transfer start, active low, one clock wide.
- RnW  in  1  1 = read, 0 = write.
- A  in  31  address A[31:1].
- D_IN  in  4  write data D[31:28] (autoconfig nibble).
- OVL  in  1  ROM overlay active.
- CIA_ENABLE  in  1  CIA access qualifier from the cycle logic.
- ROMEN  out  1  ROM select.
- CIA_SPACE  out  1  address is in $BFxxxx.
- CIACS0n  out  1  CIA-A select, active low.
- CIACS1n  out  1  CIA-B select, active low.
- RAMSPACEn  out  1  chip RAM space, active low.
- REGSPACEn  out  1  chipset register space ($DFxxxx), active low.
- AC_SPACE  out  1  access targets the unconfigured board.
- AC_DATA  out  4  autoconfig read nibble, driven onto D[31:28].
- BOARD_SELn  out  N_BOARDS  per-board select, active low.
- CONFIG_DONE  out  1  all boards configured or shut up.

Behaviour:
- Reset values: ROMEN=0, CIA_SPACE=0, AC_SPACE=0, CONFIG_DONE=0, CIACS0n=1, CIACS1n=1, RAMSPACEn=1, REGSPACEn=1, BOARD_SELn all 1, AC_DATA=4'hF. All board bases cleared; state = CFG(0).
- Z2 space is A[31:24]==8'h00. Every select additionally requires Z2 space.
- Space decode is sampled at the rising edge where TSn=0 and held until the next TSn=0. Latency is 1 clock. TSn=1 leaves the outputs unchanged.
- ROMEN = (OVL and A[23:21]==0) or A[23:19]==5'b11111.
- RAMSPACE = !OVL and A[23:21]==0.
- REGSPACE = A[23:16]==8'hDF.
- CIA_SPACE = A[23:16]==8'hBF.
- CIACS0n/CIACS1n are combinational: ~(CIA_ENABLE and !A[12]) and ~(CIA_ENABLE and !A[13]).
- Priority when decodes overlap: ROMEN > CIA_SPACE > REGSPACE > AC_SPACE > BOARD_SELn. Only one of these may be active per cycle.
- Autoconfig state machine:
  - States: CFG(k) for k=0..N_BOARDS-1, then DONE.
  - AC_SPACE = state!=DONE and A[23:16]==AC_BASE.
- Reads in AC space (offset = A[7:1]) return AC_DATA with 1-clock latency:
  - $00 → 4'hC (Z2 type, not inverted).
  - $02 → {chained, 3'b001}, not inverted; chained=1 when k<N_BOARDS-1.
  - $04/$06 → ~product ID, high/low nibble.
  - $10/$12/$14/$16 → ~MFG_ID, nibbles high to low.
  - Any other offset → 4'hF.
- Writes in AC space:
  - $4A: latch low nibble of base A[19:16]. No state change.
  - $48: latch high nibble A[23:20], commit base_k, mark board k configured, go to CFG(k+1), or DONE after the last board.
  - $4C (shut up): board k stays unconfigured, advance as for $48.
  - Other offsets: ignored.
- A write to $48 without a prior $4A uses low nibble 0.
- CONFIG_DONE=1 in DONE; AC_SPACE is then never asserted.
- BOARD_SELn[k]=0 when board k is configured, A[23:16]==base_k and no higher-priority decode applies. This is registered on TSn like the other space decodes.
- If two bases are equal, the lowest k wins.
- RESETn low mid-configuration clears all bases and returns to CFG(0) asynchronously.

Optional Feature:
- Macro AUTOVECTOR_EN adds inputs TT0 and TT1 and output AVEC (reset 0).
- With the macro, AVEC is registered on TSn: AVEC = TT0 and TT1 and A[31:16]==16'hFFFF. AVEC overrides all other selects, which are all forced inactive that cycle.
- Without the macro, none of these ports exist and CPU-space cycles decode as ordinary addresses. A[31:24]!=0 therefore yields no selects.

Test Plan:
- Reset, then TSn pulse at A=$00F80000 → ROMEN=1 one clock later; RAMSPACEn=1. Same cycle with OVL=1 at A=$00000000 → ROMEN=1, RAMSPACEn=1.
- Read $00E80000, $00E80002, $00E80010 with N_BOARDS=2, MFG_ID=16'h1234 → AC_DATA = C, 9, E; AC_SPACE=1.
- Write D=4'h9 at $00E8004A, then D=4'hE at $00E80048 → board 0 base=$E9. Access $00E91000 → BOARD_SELn=2'b10. Repeat for board 1 with base $EA → CONFIG_DONE=1; $00E80000 → AC_SPACE=0.
- Write $00E8004C on board 0, then assign board 1 base $EA → BOARD_SELn[0] never asserted; $00EA0000 → BOARD_SELn=2'b01.
- Assert RESETn low after board 0 is configured → all BOARD_SELn=1 and CONFIG_DONE=0 immediately; the next AC read at $02 returns 9 (board 0 again).
- AUTOVECTOR_EN: TT0=TT1=1, A=$FFFF000C, TSn pulse → AVEC=1 next clock, all other selects inactive. With TT0=0 → AVEC=0.

Source files
------------

// File: rtl/u409_address_decode_ac.sv
// u409_address_decode_ac
//   Registered Zorro 2 address decoder with a Zorro II autoconfig engine
//   for N_BOARDS chained 64 KB I/O boards.
//
//   Space decodes are captured on the clock edge where TSn is low. They stay
//   stable until the next TSn. The CIA chip selects are combinational.
//
//   Ports
//     CLK40, RESETn         clock, async active-low reset
//     TSn, RnW, A[31:1]     bus cycle start, direction, address
//     D_IN[3:0]             write nibble D[31:28] for autoconfig registers
//     OVL, CIA_ENABLE       ROM overlay, CIA access qualifier
//     ROMEN, CIA_SPACE      ROM select, $BFxxxx space
//     CIACS0n, CIACS1n      CIA-A / CIA-B selects (combinational)
//     RAMSPACEn, REGSPACEn  chip RAM space, $DFxxxx register space
//     AC_SPACE, AC_DATA     autoconfig window hit, read nibble
//     BOARD_SELn            per-board select on base match
//     CONFIG_DONE           all boards configured or shut up
//
//   Optional build macro AUTOVECTOR_EN adds TT0/TT1 inputs and the AVEC output.
//   A CPU-space cycle to $FFFFxxxx then asserts AVEC and suppresses every
//   other select.
//
//   Autoconfig FSM
//     state      | meaning
//     CFG(k)     | board k is visible in the autoconfig window
//     DONE       | every board configured or shut up; window closed
module u409_address_decode_ac #(
    parameter int          N_BOARDS   = 2,
    parameter logic [7:0]  AC_BASE    = 8'hE8,
    parameter logic [15:0] MFG_ID     = 16'h0000,
    parameter logic [7:0]  PRODUCT_ID = 8'h00
) (
    input  logic                CLK40,
    input  logic                RESETn,
    input  logic                TSn,
    input  logic                RnW,
    input  logic [31:1]         A,
    input  logic [3:0]          D_IN,
    input  logic                OVL,
    input  logic                CIA_ENABLE,
`ifdef AUTOVECTOR_EN
    input  logic                TT0,
    input  logic                TT1,
    output logic                AVEC,
`endif
    output logic                ROMEN,
    output logic                CIA_SPACE,
    output logic                CIACS0n,
    output logic                CIACS1n,
    output logic                RAMSPACEn,
    output logic                REGSPACEn,
    output logic                AC_SPACE,
    output logic [3:0]          AC_DATA,
    output logic [N_BOARDS-1:0] BOARD_SELn,
    output logic                CONFIG_DONE
);

    // The state is the index of the board being configured. DONE is N_BOARDS.
    localparam logic [2:0] ST_DONE = 3'(N_BOARDS);

    logic [2:0] state_q, state_d;

    // FSM outputs
    logic       ac_open;
    logic       cfg_done;
    logic [1:0] cur_k;
    logic       chained;

    // Decode
    logic       z2;
    logic       avec_hit;
    logic       rom_dec, ram_dec, cia_dec, reg_dec, ac_dec, lower_ok;
    logic [N_BOARDS-1:0] bsel_dec;
    logic       bsel_found;
    logic [7:0] byte_off;
    logic [7:0] prod_id;
    logic [3:0] ac_rdata;
    logic       ac_wr, ac_wr_lo, ac_wr_commit, ac_wr_shut;

    // Autoconfig datapath
    logic [3:0]          base_lo_q, base_lo_d;
    logic [7:0]          base_q [N_BOARDS];
    logic [7:0]          base_d [N_BOARDS];
    logic [N_BOARDS-1:0] cfg_q, cfg_d;

    // Registered outputs. Active-low selects are stored active-high.
    logic                romen_q, romen_d;
    logic                cia_q, cia_d;
    logic                ram_q, ram_d;
    logic                reg_q, reg_d;
    logic                ac_q, ac_d;
    logic [3:0]          acdata_q, acdata_d;
    logic [N_BOARDS-1:0] bsel_q, bsel_d;

    logic unused_a;
    assign unused_a = ^{A[15:14], A[11:8]};

    // ---------------- Autoconfig FSM ----------------
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) state_q <= 3'd0;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ac_wr_commit || ac_wr_shut)
            state_d = state_q + 3'd1;
    end

    always_comb begin
        ac_open  = (state_q != ST_DONE);
        cfg_done = (state_q == ST_DONE);
        cur_k    = state_q[1:0];
        chained  = (state_q < 3'(N_BOARDS - 1));
    end

    // ---------------- Address decode ----------------
`ifdef AUTOVECTOR_EN
    assign avec_hit = TT0 && TT1 && (A[31:16] == 16'hFFFF);
`else
    assign avec_hit = 1'b0;
`endif

    always_comb begin
        z2       = (A[31:24] == 8'h00) && !avec_hit;
        rom_dec  = z2 && ((OVL && A[23:21] == 3'b000) || A[23:19] == 5'b11111);
        ram_dec  = z2 && !OVL && (A[23:21] == 3'b000);
        cia_dec  = z2 && !rom_dec && (A[23:16] == 8'hBF);
        reg_dec  = z2 && !rom_dec && !cia_dec && (A[23:16] == 8'hDF);
        ac_dec   = z2 && !rom_dec && !cia_dec && !reg_dec && ac_open
                   && (A[23:16] == AC_BASE);
        lower_ok = z2 && !rom_dec && !cia_dec && !reg_dec && !ac_dec;
    end

    // Lowest-numbered configured board wins when bases collide.
    always_comb begin
        bsel_dec   = '0;
        bsel_found = 1'b0;
        for (int k = 0; k < N_BOARDS; k++) begin
            if (!bsel_found && lower_ok && cfg_q[k] && (A[23:16] == base_q[k])) begin
                bsel_dec[k] = 1'b1;
                bsel_found  = 1'b1;
            end
        end
    end

    // Autoconfig register file. Offsets are byte offsets within the window.
    always_comb begin
        byte_off = {A[7:1], 1'b0};
        prod_id  = PRODUCT_ID + {6'd0, cur_k};
        case (byte_off)
            8'h00:   ac_rdata = 4'hC;
            8'h02:   ac_rdata = {chained, 3'b001};
            8'h04:   ac_rdata = ~prod_id[7:4];
            8'h06:   ac_rdata = ~prod_id[3:0];
            8'h10:   ac_rdata = ~MFG_ID[15:12];
            8'h12:   ac_rdata = ~MFG_ID[11:8];
            8'h14:   ac_rdata = ~MFG_ID[7:4];
            8'h16:   ac_rdata = ~MFG_ID[3:0];
            default: ac_rdata = 4'hF;
        endcase
        ac_wr        = !TSn && !RnW && ac_dec;
        ac_wr_lo     = ac_wr && (byte_off == 8'h4A);
        ac_wr_commit = ac_wr && (byte_off == 8'h48);
        ac_wr_shut   = ac_wr && (byte_off == 8'h4C);
    end

    // The pending low nibble is cleared when a board leaves the window, so a
    // $48 write without a preceding $4A write commits a low nibble of 0.
    always_comb begin
        base_lo_d = base_lo_q;
        cfg_d     = cfg_q;
        for (int k = 0; k < N_BOARDS; k++) base_d[k] = base_q[k];
        if (ac_wr_lo) base_lo_d = D_IN;
        if (ac_wr_commit || ac_wr_shut) base_lo_d = 4'h0;
        for (int k = 0; k < N_BOARDS; k++) begin
            if (ac_wr_commit && (cur_k == 2'(k))) begin
                base_d[k] = {D_IN, base_lo_q};
                cfg_d[k]  = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            base_lo_q <= 4'h0;
            cfg_q     <= '0;
            for (int k = 0; k < N_BOARDS; k++) base_q[k] <= 8'h00;
        end else begin
            base_lo_q <= base_lo_d;
            cfg_q     <= cfg_d;
            for (int k = 0; k < N_BOARDS; k++) base_q[k] <= base_d[k];
        end
    end

    // ---------------- Output registers ----------------
    always_comb begin
        romen_d  = romen_q;
        cia_d    = cia_q;
        ram_d    = ram_q;
        reg_d    = reg_q;
        ac_d     = ac_q;
        acdata_d = acdata_q;
        bsel_d   = bsel_q;
        if (!TSn) begin
            romen_d  = rom_dec;
            cia_d    = cia_dec;
            ram_d    = ram_dec;
            reg_d    = reg_dec;
            ac_d     = ac_dec;
            acdata_d = (ac_dec && RnW) ? ac_rdata : 4'hF;
            bsel_d   = bsel_dec;
        end
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            romen_q  <= 1'b0;
            cia_q    <= 1'b0;
            ram_q    <= 1'b0;
            reg_q    <= 1'b0;
            ac_q     <= 1'b0;
            acdata_q <= 4'hF;
            bsel_q   <= '0;
        end else begin
            romen_q  <= romen_d;
            cia_q    <= cia_d;
            ram_q    <= ram_d;
            reg_q    <= reg_d;
            ac_q     <= ac_d;
            acdata_q <= acdata_d;
            bsel_q   <= bsel_d;
        end
    end

`ifdef AUTOVECTOR_EN
    logic avec_q, avec_d;

    always_comb begin
        avec_d = avec_q;
        if (!TSn) avec_d = avec_hit;
    end

    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) avec_q <= 1'b0;
        else         avec_q <= avec_d;
    end

    assign AVEC = avec_q;
`endif

    assign ROMEN       = romen_q;
    assign CIA_SPACE   = cia_q;
    assign RAMSPACEn   = ~ram_q;
    assign REGSPACEn   = ~reg_q;
    assign AC_SPACE    = ac_q;
    assign AC_DATA     = acdata_q;
    assign BOARD_SELn  = ~bsel_q;
    assign CONFIG_DONE = cfg_done;
    // CPU-space autovector cycles must not select a CIA.
    assign CIACS0n     = ~(CIA_ENABLE && !A[12] && !avec_hit);
    assign CIACS1n     = ~(CIA_ENABLE && !A[13] && !avec_hit);

endmodule

// File: tb/tb_u409_address_decode_ac.sv
module tb_u409_address_decode_ac;

    localparam int          N    = 2;
    localparam logic [15:0] MFG  = 16'h1234;
    localparam logic [7:0]  PID  = 8'h35;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tsn = 1'b1;
    logic          rnw = 1'b1;
    logic [31:1]   a_bus = '0;
    logic [3:0]    d_in = 4'h0;
    logic          ovl = 1'b0;
    logic          cia_en = 1'b0;

    logic          romen, cia_space, cs0n, cs1n, ramn, regn, ac_space, cfg_done;
    logic [3:0]    ac_data;
    logic [N-1:0]  bseln;

    always #5 clk = ~clk;

    u409_address_decode_ac #(
        .N_BOARDS(N), .AC_BASE(8'hE8), .MFG_ID(MFG), .PRODUCT_ID(PID)
    ) dut (
        .CLK40(clk), .RESETn(rst_n), .TSn(tsn), .RnW(rnw), .A(a_bus),
        .D_IN(d_in), .OVL(ovl), .CIA_ENABLE(cia_en),
        .ROMEN(romen), .CIA_SPACE(cia_space), .CIACS0n(cs0n), .CIACS1n(cs1n),
        .RAMSPACEn(ramn), .REGSPACEn(regn), .AC_SPACE(ac_space),
        .AC_DATA(ac_data), .BOARD_SELn(bseln), .CONFIG_DONE(cfg_done)
    );

    typedef struct {
        logic         romen, cia, ramn, regn, ac, done, cs0n, cs1n;
        logic [3:0]   acd;
        logic [N-1:0] bseln;
    } exp_t;

    exp_t q[$];
    exp_t last;

    // Reference model: which board is in the window, and what each board holds.
    int         cur;
    logic [7:0] base [N];
    bit         cfgd [N];
    logic [3:0] lo;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  drv_active = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ac_nib(input int off);
        logic [7:0]  prod;
        logic [15:0] m;
        prod = PID + 8'(cur);
        if (off == 0)                return 4'hC;
        if (off == 2)                return (cur < N - 1) ? 4'h9 : 4'h1;
        if (off == 4)                return ~(prod / 16);
        if (off == 6)                return ~(prod % 16);
        if (off >= 'h10 && off <= 'h16) begin
            m = MFG >> (4 * (3 - (off - 'h10) / 2));
            return ~m[3:0];
        end
        return 4'hF;
    endfunction

    task automatic model_reset();
        cur = 0;
        lo  = 4'h0;
        for (int k = 0; k < N; k++) begin
            base[k] = 8'h00;
            cfgd[k] = 1'b0;
        end
        last.romen = 0; last.cia = 0; last.ramn = 1; last.regn = 1;
        last.ac = 0; last.acd = 4'hF; last.bseln = '1; last.done = 0;
        last.cs0n = 1; last.cs1n = 1;
    endtask

    // One bus clock: drive inputs, predict, enqueue, advance one edge.
    task automatic bus(input bit ts, input logic [31:0] addr, input bit rd,
                       input logic [3:0] d, input bit ov, input bit ce);
        exp_t e;
        bit   z2, hi;
        int   seg, off;
        a_bus = addr[31:1]; tsn = ~ts; rnw = rd; d_in = d; ovl = ov; cia_en = ce;
        e   = last;
        z2  = (addr[31:24] == 0);
        seg = int'(addr[23:16]);
        off = int'(addr[7:0]) & 'hFE;
        if (ts) begin
            e.romen = z2 && ((ov && addr[23:21] == 0) || addr[23:19] == 5'h1F);
            e.ramn  = !(z2 && !ov && addr[23:21] == 0);
            e.cia   = z2 && !e.romen && seg == 'hBF;
            e.regn  = !(z2 && !e.romen && !e.cia && seg == 'hDF);
            hi      = e.romen || e.cia || !e.regn;
            e.ac    = z2 && !hi && cur < N && seg == 'hE8;
            e.acd   = (e.ac && rd) ? ac_nib(off) : 4'hF;
            e.bseln = '1;
            if (z2 && !hi && !e.ac) begin
                for (int k = N - 1; k >= 0; k--)
                    if (cfgd[k] && base[k] == addr[23:16]) e.bseln = ~(N'(1) << k);
            end
            if (e.ac && !rd) begin
                if (off == 'h4A) lo = d;
                if (off == 'h48) begin
                    base[cur] = {d, lo};
                    cfgd[cur] = 1'b1;
                end
                if (off == 'h48 || off == 'h4C) begin
                    lo  = 4'h0;
                    cur = cur + 1;
                end
            end
        end
        e.done = (cur == N);
        e.cs0n = !(ce && !addr[12]);
        e.cs1n = !(ce && !addr[13]);
        last = e;
        q.push_back(e);
        drv_active = 1'b1;
        @(posedge clk);
        #2;
        tsn = 1'b1;
        drv_active = 1'b0;
    endtask

    // Monitor: every clock that the driver owns, pop a prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (drv_active) begin
                #1;
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard_underflow: got empty queue expected one entry");
                end else begin
                    e = q.pop_front();
                    chk("ROMEN", romen, e.romen);
                    chk("CIA_SPACE", cia_space, e.cia);
                    chk("RAMSPACEn", ramn, e.ramn);
                    chk("REGSPACEn", regn, e.regn);
                    chk("AC_SPACE", ac_space, e.ac);
                    chk("AC_DATA", ac_data, e.acd);
                    chk("BOARD_SELn", bseln, e.bseln);
                    chk("CONFIG_DONE", cfg_done, e.done);
                    chk("CIACS0n", cs0n, e.cs0n);
                    chk("CIACS1n", cs1n, e.cs1n);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_ROMEN"}, romen, 1'b0);
        chk({tag, "_CIA_SPACE"}, cia_space, 1'b0);
        chk({tag, "_AC_SPACE"}, ac_space, 1'b0);
        chk({tag, "_CONFIG_DONE"}, cfg_done, 1'b0);
        chk({tag, "_RAMSPACEn"}, ramn, 1'b1);
        chk({tag, "_REGSPACEn"}, regn, 1'b1);
        chk({tag, "_BOARD_SELn"}, bseln, {N{1'b1}});
        chk({tag, "_AC_DATA"}, ac_data, 4'hF);
    endtask

    // Asynchronous reset between bus cycles; checked before any clock edge.
    task automatic pulse_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 check_reset_values(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0]  offs [12];
        logic [7:0]  segs [6];
        logic [31:0] r;
        offs = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h10, 8'h12, 8'h14, 8'h16,
                 8'h48, 8'h4A, 8'h4C, 8'h20};
        segs = '{8'hF8, 8'hFF, 8'h00, 8'h1F, 8'hBF, 8'hDF};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r = {8'h00, 8'hE8, r[15:8], offs[$urandom_range(0, 11)]};
            1: r = {8'h00, 8'(8'hE0 + $urandom_range(0, 15)), r[15:0]};
            2: r = {8'h00, segs[$urandom_range(0, 5)], r[15:0]};
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Plain space decode and overlay
        bus(1, 32'h00F80000, 1, 4'h0, 0, 0);
        chk("plan_rom_f8", romen, 1'b1);
        chk("plan_ram_f8", ramn, 1'b1);
        bus(1, 32'h00000000, 1, 4'h0, 1, 0);
        chk("plan_rom_ovl", romen, 1'b1);
        chk("plan_ram_ovl", ramn, 1'b1);
        bus(1, 32'h00000000, 1, 4'h0, 0, 1);
        bus(0, 32'h00BF0000, 1, 4'h0, 0, 1);
        chk("plan_hold_tsn1", ramn, 1'b0);
        bus(1, 32'h00BFE001, 1, 4'h0, 0, 1);
        bus(1, 32'h00DFF000, 1, 4'h0, 0, 0);
        bus(1, 32'h01F80000, 1, 4'h0, 1, 0);

        // Autoconfig reads of board 0
        bus(1, 32'h00E80000, 1, 4'h0, 0, 0);
        chk("plan_ac_00", ac_data, 4'hC);
        chk("plan_ac_space", ac_space, 1'b1);
        bus(1, 32'h00E80002, 1, 4'h0, 0, 0);
        chk("plan_ac_02", ac_data, 4'h9);
        bus(1, 32'h00E80010, 1, 4'h0, 0, 0);
        chk("plan_ac_10", ac_data, 4'hE);
        bus(1, 32'h00E80004, 1, 4'h0, 0, 0);
        bus(1, 32'h00E80006, 1, 4'h0, 0, 0);
        bus(1, 32'h00E80016, 1, 4'h0, 0, 0);
        bus(1, 32'h00E80030, 1, 4'h0, 0, 0);

        // Configure board 0 at $E9, board 1 at $EA
        bus(1, 32'h00E8004A, 0, 4'h9, 0, 0);
        bus(1, 32'h00E80048, 0, 4'hE, 0, 0);
        bus(1, 32'h00E91000, 1, 4'h0, 0, 0);
        chk("plan_bsel_b0", bseln, 2'b10);
        bus(1, 32'h00E80002, 1, 4'h0, 0, 0);
        chk("plan_ac_02_b1", ac_data, 4'h1);
        bus(1, 32'h00E8004A, 0, 4'hA, 0, 0);
        bus(1, 32'h00E80048, 0, 4'hE, 0, 0);
        chk("plan_done", cfg_done, 1'b1);
        bus(1, 32'h00E80000, 1, 4'h0, 0, 0);
        chk("plan_ac_closed", ac_space, 1'b0);
        bus(1, 32'h00EA0000, 1, 4'h0, 0, 0);
        chk("plan_bsel_b1", bseln, 2'b01);

        // Shut-up on board 0, board 1 at $EA
        pulse_reset("rst_done");
        bus(1, 32'h00E8004C, 0, 4'h0, 0, 0);
        bus(1, 32'h00E8004A, 0, 4'hA, 0, 0);
        bus(1, 32'h00E80048, 0, 4'hE, 0, 0);
        bus(1, 32'h00E00000, 1, 4'h0, 0, 0);
        chk("plan_shutup_b0", bseln, 2'b11);
        bus(1, 32'h00EA0000, 1, 4'h0, 0, 0);
        chk("plan_shutup_b1", bseln, 2'b01);

        // Reset after board 0 is configured
        pulse_reset("rst_cfg");
        bus(1, 32'h00E80048, 0, 4'hE, 0, 0);
        bus(1, 32'h00E00000, 1, 4'h0, 0, 0);
        chk("plan_lo_default", bseln, 2'b10);
        pulse_reset("rst_mid");
        bus(1, 32'h00E80002, 1, 4'h0, 0, 0);
        chk("plan_ac_02_after_rst", ac_data, 4'h9);

        // Randomised traffic with periodic resets
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < 80; i++)
                bus(($urandom_range(0, 4) != 0), rand_addr(), $urandom_range(0, 1),
                    4'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
            pulse_reset("rst_rand");
        end

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
